// File: rtl/decoder_nto2n_seq.sv
// N-to-2^N decoder with a ready/valid output stream.
// DIRECT emits one decoded beat; SWEEP walks a single set bit from 0 up to the code.
module decoder_nto2n_seq #(
  parameter int N = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic [N-1:0]        in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [(2**N)-1:0]   out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy
);

  localparam int W = 2**N;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIRECT = 2'd1,
    S_SWEEP  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   code_q, code_d;
  logic [N-1:0]   step_q, step_d;
  logic [N-1:0]   step_inc;
  logic [W-1:0]   out_d;
  logic           valid_d;
  logic           last_d;
  logic           fire_out;
  logic           accept;
  logic [W-1:0]   one;

  assign one      = W'(1);
  assign fire_out = out_valid && out_ready;
  assign in_ready = (state_q == S_IDLE) || (fire_out && out_last);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != S_IDLE);
  assign step_inc = step_q + N'(1);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    step_d  = step_q;
    out_d   = out;
    valid_d = out_valid;
    last_d  = out_last;

    if (fire_out && out_last) begin
      state_d = S_IDLE;
      step_d  = '0;
      out_d   = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else if (fire_out && (state_q == S_SWEEP)) begin
      step_d = step_inc;
      out_d  = one << step_inc;
      last_d = (step_inc == code_q);
    end

    // A new code may overwrite the retiring last beat on the same edge.
    if (accept) begin
      code_d  = in;
      step_d  = '0;
      valid_d = 1'b1;
      if (!mode) begin
        state_d = S_DIRECT;
        out_d   = en ? (one << in) : '0;
        last_d  = 1'b1;
      end else begin
        state_d = S_SWEEP;
        out_d   = en ? one : '0;
        last_d  = !en || (in == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      code_q    <= '0;
      step_q    <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      step_q    <= step_d;
      out       <= out_d;
      out_valid <= valid_d;
      out_last  <= last_d;
    end
  end

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Scoreboard bench for decoder_nto2n_seq: an N=2 and an N=3 instance share one driver,
// expected beats are queued at acceptance and compared as the DUT transfers them.
module tb_decoder_nto2n_seq;

  typedef struct packed {
    logic [63:0] pat;
    logic        last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, mode, iv, sel, out_ready, bp;
  logic [5:0] code;

  logic       r2, ov2, ol2, b2;
  logic [3:0] o2;
  logic       r3, ov3, ol3, b3;
  logic [7:0] o3;

  beat_t q2[$];
  beat_t q3[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decoder_nto2n_seq #(.N(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in(code[1:0]),
    .in_valid(iv && !sel), .in_ready(r2), .out(o2), .out_valid(ov2),
    .out_ready(out_ready), .out_last(ol2), .busy(b2)
  );

  decoder_nto2n_seq #(.N(3)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in(code[2:0]),
    .in_valid(iv && sel), .in_ready(r3), .out(o3), .out_valid(ov3),
    .out_ready(out_ready), .out_last(ol3), .busy(b3)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired at %0t", tag, $time);
  endtask

  // Reference model: the full beat list of one code, independent of the DUT's structure.
  task automatic push_exp(input logic s, input int c, input logic m, input logic e,
                          output logic [63:0] first);
    beat_t b;
    first = 64'(0);
    if (!m || !e) begin
      b.pat  = e ? (64'(1) << c) : 64'(0);
      b.last = 1'b1;
      first  = b.pat;
      if (s) q3.push_back(b); else q2.push_back(b);
    end else begin
      for (int k = 0; k <= c; k++) begin
        b.pat  = 64'(1) << k;
        b.last = (k == c);
        if (k == 0) first = b.pat;
        if (s) q3.push_back(b); else q2.push_back(b);
      end
    end
  endtask

  task automatic send(input logic s, input int c, input logic m, input logic e);
    int t;
    logic [63:0] first;
    @(negedge clk);
    sel = s; code = 6'(c); mode = m; en = e; iv = 1'b1;
    t = 0;
    while (!(s ? r3 : r2) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      timeout("accept_wait");
      iv = 1'b0;
      return;
    end
    push_exp(s, c, m, e, first);
    @(posedge clk);
    #1;
    iv = 1'b0;
    code = 6'($urandom); en = 1'($urandom); mode = 1'($urandom);
    chk("first_valid", 64'(s ? ov3 : ov2), 64'(1));
    chk("first_out", s ? 64'(o3) : 64'(o2), first);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((q2.size() != 0 || q3.size() != 0 || ov2 || ov3) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) timeout("drain");
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy2", 64'(b2), 64'(ov2));
      if (!ov2) chk("idle_zero2", 64'(o2), 64'(0));
      else begin
        if (!ol2) chk("ready_low2", 64'(r2), 64'(0));
        if (q2.size() == 0) timeout("extra_beat2");
        else begin
          chk("beat2", 64'(o2), q2[0].pat);
          chk("last2", 64'(ol2), 64'(q2[0].last));
          if (out_ready) void'(q2.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy3", 64'(b3), 64'(ov3));
      if (!ov3) chk("idle_zero3", 64'(o3), 64'(0));
      else begin
        if (!ol3) chk("ready_low3", 64'(r3), 64'(0));
        if (q3.size() == 0) timeout("extra_beat3");
        else begin
          chk("beat3", 64'(o3), q3[0].pat);
          chk("last3", 64'(ol3), 64'(q3[0].last));
          if (out_ready) void'(q3.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    rst = 1'b1; iv = 1'b0; sel = 1'b0; en = 1'b0; mode = 1'b0; code = '0;
    out_ready = 1'b1; bp = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready2", 64'(r2), 64'(1));
    chk("rst_ready3", 64'(r3), 64'(1));
    chk("rst_valid2", 64'(ov2), 64'(0));
    chk("rst_out3", 64'(o3), 64'(0));
    chk("rst_busy2", 64'(b2), 64'(0));

    for (int c = 0; c < 4; c++) send(1'b0, c, 1'b0, 1'b1);
    send(1'b0, 2, 1'b0, 1'b0);
    send(1'b0, 3, 1'b1, 1'b1);
    send(1'b0, 1, 1'b0, 1'b1);
    send(1'b0, 2, 1'b1, 1'b0);
    send(1'b0, 0, 1'b1, 1'b1);
    wait_drain();

    // Sweep of code 5 on the 3-bit instance, stalled for three cycles on beat 2.
    send(1'b1, 5, 1'b1, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("stall_out", 64'(o3), 64'h04);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_hold", 64'(o3), 64'h04);
    out_ready = 1'b1;
    wait_drain();

    send(1'b1, 7, 1'b1, 1'b1);
    send(1'b1, 7, 1'b0, 1'b1);
    send(1'b1, 0, 1'b0, 1'b1);
    wait_drain();

    bp = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i[0]) send(1'b1, $urandom_range(0, 7), 1'($urandom), 1'($urandom));
      else      send(1'b0, $urandom_range(0, 3), 1'($urandom), 1'($urandom));
    end
    bp = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain();

    // Reset in the middle of a sweep, with a code offered during reset.
    send(1'b0, 3, 1'b1, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1; sel = 1'b0; code = 6'd2; mode = 1'b0; en = 1'b1; iv = 1'b1;
    @(posedge clk);
    #1;
    q2.delete();
    chk("mid_rst_valid", 64'(ov2), 64'(0));
    chk("mid_rst_out", 64'(o2), 64'(0));
    chk("mid_rst_busy", 64'(b2), 64'(0));
    chk("mid_rst_ready", 64'(r2), 64'(1));
    @(posedge clk);
    #1;
    rst = 1'b0; iv = 1'b0;
    chk("rst_no_accept", 64'(ov2), 64'(0));
    chk("post_rst_ready", 64'(r2), 64'(1));
    send(1'b0, 1, 1'b0, 1'b1);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
